button_event: RTL

- Sits directly downstream of the debouncer in the 4-digit 7-segment timer.
- Takes one clean, debounced button level and turns it into single-cycle event pulses: press, release, short-click, long-press and auto-repeat, plus a held level.
- The timer control logic consumes these events, e.g. start/stop on short click, clear on long press, fast digit increment on repeat.
- Pure synchronous logic; it does no debouncing of its own.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/hold_counter.sv | 27 ++
 rtl/button_event.sv | 122 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the 4-digit 7-segment timer: button FSM state
// encodings, system clock constants and millisecond/tick conversion helpers.
package timer_pkg;

  typedef enum logic [1:0] {
    S_ARM   = 2'd0,
    S_IDLE  = 2'd1,
    S_PRESS = 2'd2,
    S_HELD  = 2'd3
  } state_t;

  localparam int unsigned C_CLKFREQ   = 100_000_000;
  localparam int unsigned C_LONG_MS   = 1000;
  localparam int unsigned C_REPEAT_MS = 200;

  // Clock cycles in the given number of milliseconds.
  function automatic int unsigned ms_to_ticks(input int unsigned ms);
    return (C_CLKFREQ / 1000) * ms;
  endfunction

  // Clock cycles in the given number of microseconds.
  function automatic int unsigned us_to_ticks(input int unsigned us);
    return (C_CLKFREQ / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Clearable, enable-gated up-counter with a terminal-count compare output.
// Clear has priority over enable; the compare value is supplied by the user.
module hold_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_tc,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: synchronous reset, then clear, then increment.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == i_tc);

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle press / release /
// short-click / long-press / auto-repeat pulses plus a held level.
module button_event
  import timer_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = ms_to_ticks(C_LONG_MS),
  parameter int unsigned REPEAT_TICKS = ms_to_ticks(C_REPEAT_MS),
  parameter bit          REPEAT_EN    = 1'b1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o,
  output logic release_o,
  output logic short_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] L_LONG_TC   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] L_REPEAT_TC = CNT_W'(REPEAT_TICKS - 1);

  state_t           r_state;
  logic             r_press, r_release, r_short, r_long, r_repeat, r_held;
  logic             w_clr, w_en, w_tc;
  logic [CNT_W-1:0] w_tc_val;

  hold_counter #(.CNT_W(CNT_W)) u_hold_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_en  (w_en),
    .i_tc  (w_tc_val),
    .o_tc  (w_tc)
  );

  // Counter control: select the threshold for the current state and decide
  // whether the hold counter clears, counts, or (repeat disabled) saturates.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    w_clr    = 1'b0;
    w_en     = 1'b0;
    w_tc_val = (r_state == S_HELD) ? L_REPEAT_TC : L_LONG_TC;
    case (r_state)
      S_PRESS: begin
        if (!btn_i || w_tc) w_clr = 1'b1;
        else                w_en  = 1'b1;
      end
      S_HELD: begin
        if (!btn_i)    w_clr = 1'b1;
        else if (w_tc) w_clr = REPEAT_EN;
        else           w_en  = 1'b1;
      end
      default: w_clr = 1'b1;
    endcase
  end

  // Button FSM with registered event pulses and held level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_ARM;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      case (r_state)
        S_ARM: begin
          if (!btn_i) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (btn_i) begin
            r_state <= S_PRESS;
            r_press <= 1'b1;
          end
        end
        S_PRESS: begin
          if (!btn_i) begin
            r_release <= 1'b1;
            r_short   <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_tc) begin
            r_long  <= 1'b1;
            r_held  <= 1'b1;
            r_state <= S_HELD;
          end
        end
        S_HELD: begin
          if (!btn_i) begin
            r_release <= 1'b1;
            r_held    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (REPEAT_EN && w_tc) begin
            r_repeat <= 1'b1;
          end
        end
        default: begin
          r_state <= S_ARM;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign press_o   = r_press;
  assign release_o = r_release;
  assign short_o   = r_short;
  assign long_o    = r_long;
  assign repeat_o  = r_repeat;
  assign held_o    = r_held;

endmodule
